// File: rtl/circular_counter.sv
// circular_counter
//
// Modular counter for control sequencing (address/index generation,
// round-robin pointers). Each enabled edge moves the count by `step`, up or
// down, inside the inclusive window [min_val, max_val]. Leaving the window
// wraps circularly to the far bound, and the update that wrapped raises a
// one-cycle `wrap` pulse. A synchronous load places a value directly into the
// window.
//
// Optional feature macro: WRAP_COUNT_EN
//   Defined   : adds parameter WRAPS_WIDTH and output wrap_count. The counter
//               counts wraps since reset and saturates at its maximum.
//   Undefined : no wrap_count port and no wrap_count register.
//
// Ports
//   clk        in   1            clock, rising edge
//   rst        in   1            synchronous active-high reset
//   enable     in   1            advance by one step this cycle
//   down       in   1            0 = count up, 1 = count down
//   step       in   WIDTH        step magnitude; 0 holds the count
//   min_val    in   WIDTH        lower bound, inclusive
//   max_val    in   WIDTH        upper bound, inclusive (min_val <= max_val)
//   load       in   1            synchronous load request
//   load_val   in   WIDTH        value to load
//   out        out  WIDTH        registered count
//   wrap       out  1            registered pulse: the last update wrapped
//   wrap_count out  WRAPS_WIDTH  saturating wrap count (WRAP_COUNT_EN only)
//
// Update priority on each edge: rst > load > enable > hold.

module circular_counter #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
`ifdef WRAP_COUNT_EN
  ,
  parameter int unsigned      WRAPS_WIDTH = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             down,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] min_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             wrap
`ifdef WRAP_COUNT_EN
  ,
  output logic [WRAPS_WIDTH-1:0] wrap_count
`endif
);

  // All window arithmetic is done one bit wider than the count so that no
  // intermediate sum can overflow.
  localparam int unsigned EW = WIDTH + 1;

  localparam logic [EW-1:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_d;
  logic             wrap_q;
  logic             wrap_d;

  // Widened operands and intermediate results.
  logic [EW-1:0] out_x;
  logic [EW-1:0] step_x;
  logic [EW-1:0] min_x;
  logic [EW-1:0] max_x;
  logic [EW-1:0] span_x;      // max - min
  logic [EW-1:0] up_sum_x;    // out + step
  logic [EW-1:0] up_over_x;   // how far past max the up step lands, minus one
  logic [EW-1:0] up_t_x;      // wrapped up result
  logic [EW-1:0] dn_floor_x;  // min + step: smallest out that steps down without wrap
  logic [EW-1:0] dn_def_x;    // how far below min the down step lands, minus one
  logic [EW-1:0] dn_t_x;      // wrapped down result

  logic load_in_window_s;
  logic out_in_window_s;
  logic step_active_s;

  // Widen operands and form all candidate results for this edge.
  always_comb begin
    out_x      = {1'b0, out_q};
    step_x     = {1'b0, step};
    min_x      = {1'b0, min_val};
    max_x      = {1'b0, max_val};
    span_x     = max_x - min_x;
    up_sum_x   = out_x + step_x;
    up_over_x  = up_sum_x - max_x - ONE_X;
    up_t_x     = min_x + up_over_x;
    dn_floor_x = min_x + step_x;
    dn_def_x   = dn_floor_x - out_x - ONE_X;
    dn_t_x     = max_x - dn_def_x;

    load_in_window_s = (load_val >= min_val) && (load_val <= max_val);
    out_in_window_s  = (out_q >= min_val) && (out_q <= max_val);
    step_active_s    = enable && (step != {WIDTH{1'b0}});
  end

  // Next count and wrap flag, in priority order load > step > hold.
  // A wrapped result lies inside the window exactly when the overshoot
  // (minus one) does not exceed the window span; otherwise the step is
  // wider than the window and the count parks on the entry bound.
  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
    if (load) begin
      if (load_in_window_s) begin
        out_d = load_val;
      end else begin
        out_d = min_val;
      end
    end else if (step_active_s) begin
      if (!out_in_window_s) begin
        // Re-enter the window at the bound we are heading away from.
        case (down)
          1'b0:    out_d = min_val;
          1'b1:    out_d = max_val;
          default: out_d = min_val;
        endcase
      end else if (!down) begin
        if (up_sum_x <= max_x) begin
          out_d = up_sum_x[WIDTH-1:0];
        end else begin
          wrap_d = 1'b1;
          if (up_over_x <= span_x) begin
            out_d = up_t_x[WIDTH-1:0];
          end else begin
            out_d = min_val;
          end
        end
      end else begin
        if (out_x >= dn_floor_x) begin
          out_d = out_q - step;
        end else begin
          wrap_d = 1'b1;
          if (dn_def_x <= span_x) begin
            out_d = dn_t_x[WIDTH-1:0];
          end else begin
            out_d = max_val;
          end
        end
      end
    end else begin
      out_d  = out_q;
      wrap_d = 1'b0;
    end
  end

  // Count and wrap registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= RESET_VAL;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = out_q;
  assign wrap = wrap_q;

`ifdef WRAP_COUNT_EN
  logic [WRAPS_WIDTH-1:0] wrap_count_q;
  logic [WRAPS_WIDTH-1:0] wrap_count_d;

  // Saturating wrap counter; load leaves it untouched.
  always_comb begin
    wrap_count_d = wrap_count_q;
    if (wrap_d && (wrap_count_q != {WRAPS_WIDTH{1'b1}})) begin
      wrap_count_d = wrap_count_q + {{(WRAPS_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      wrap_count_d = wrap_count_q;
    end
  end

  // Wrap counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_count_q <= {WRAPS_WIDTH{1'b0}};
    end else begin
      wrap_count_q <= wrap_count_d;
    end
  end

  assign wrap_count = wrap_count_q;
`endif

endmodule

// File: doc/circular_counter.md
Name: circular_counter

Overview:
Parametrised modular counter for control sequencing (address/index generation, round-robin pointers). Steps by a programmable increment, up or down, inside a programmable [min_val, max_val] window. Wraps circularly and flags each wrap. Supports a synchronous load and optional wrap counting.

Parameters:
WIDTH, 4, bit width of the count and of all bound/step inputs
RESET_VAL, 0, value of out after reset (WIDTH bits; need not lie inside the window)
WRAPS_WIDTH, 8, width of wrap_count (only with optional feature)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
enable  input  1  advance by one step this cycle
down  input  1  0 = count up, 1 = count down; sampled per cycle
step  input  WIDTH  increment magnitude; 0 = hold
min_val  input  WIDTH  lower bound, inclusive
max_val  input  WIDTH  upper bound, inclusive; min_val <= max_val required
load  input  1  synchronous load request
load_val  input  WIDTH  value to load
out  output  WIDTH  registered count
wrap  output  1  registered one-cycle pulse: the update that produced out wrapped
wrap_count  output  WRAPS_WIDTH  wraps since reset (only with WRAP_COUNT_EN)

Behaviour:
- Reset (rst=1 at posedge): out=RESET_VAL, wrap=0, wrap_count=0. Reset overrides load and enable. Reset mid-sequence abandons the sequence.
- All outputs are registered. Update latency is 1 cycle: inputs sampled at edge N appear on out after edge N.
- Priority per edge: rst > load > enable > hold.
- Load:
  - load_val inside [min_val,max_val]: out=load_val.
  - Otherwise: out=min_val.
  - wrap=0.
- Hold (enable=0, or step=0): out unchanged, wrap=0.
- Out-of-window recovery: enabled step while out<min_val or out>max_val → out=min_val if up, max_val if down. wrap=0.
- Up step (in window). Compute s = out + step in WIDTH+1 bits:
  - s <= max_val: out=s, wrap=0.
  - s > max_val: t = min_val + (s - max_val - 1), computed in WIDTH+1 bits. out = t if t <= max_val, else min_val (step larger than window). wrap=1.
- Down step (in window):
  - out >= min_val + step (WIDTH+1 bits): out = out - step, wrap=0.
  - Otherwise: t = max_val - (min_val + step - out - 1), signed/extended. out = t if t >= min_val, else max_val. wrap=1.
- Single-value window (min_val==max_val): every enabled nonzero step keeps out=min_val and asserts wrap.
- Bounds, step and down may change on any cycle. They take effect at the next enabled edge; no internal latching.
- No arithmetic may overflow silently: all intermediate sums use WIDTH+1 bits. Max window 0..2^WIDTH-1 with step 1 behaves as a plain wrapping counter.

Optional Feature:
WRAP_COUNT_EN:
- Defined: adds output wrap_count. It increments on every edge that sets wrap=1, saturates at 2^WRAPS_WIDTH-1, and is cleared only by rst (load does not clear it).
- Undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- WIDTH=4, RESET_VAL=0, min=0, max=2, step=1, up, enable held → out sequence 0,1,2,0,1,2…; wrap=1 exactly on each cycle out returns to 0.
- min=3, max=9, step=4, up, from out=3 → 7, 4 (wrap), 8, 5 (wrap); down from 5, step=4 → 8 (wrap), 4, 7 (wrap).
- After reset out=0 with min=5, max=10, step=2, up → first step gives 5 with wrap=0, then 7, 9, 5 (wrap, since 11→5).
- load=1 with load_val=12 and enable=1, window 2..8 → out=2 next cycle. Then load_val=6 → out=6. Then load=0, step=0, enable=1 → out stays 6, wrap=0.
- step=15, window 0..15, up from 0 → 15, 14 (wrap), 13 (wrap)… Window 4..4 → out stays 4 with wrap every enabled cycle.
- rst asserted mid-count (out=7, enable=1, load=1) → out=0, wrap=0 (and wrap_count=0 with WRAP_COUNT_EN). With WRAP_COUNT_EN and WRAPS_WIDTH=2, 5 wraps → wrap_count reads 3 and stays there.
